window_3x3_line_buffer: RTL and testbench

//  Streaming 3x3 neighbourhood generator that sits directly upstream of the atmospheric light estimator.

---
 rtl/window_3x3_line_buffer.sv | 163 ++++++++++++++++
 tb/tb_window_3x3_line_buffer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_3x3_line_buffer.sv
// Streaming 3x3 window generator for raster-order RGB pixels.
// Two line buffers hold the previous rows; a two-column register pair plus
// the freshly assembled column form the window. Borders replicate edge
// pixels, and the final W+1 windows are self-flushed after the last input.
module window_3x3_line_buffer #(
   parameter int IMG_WIDTH  = 512,
   parameter int IMG_HEIGHT = 512,
   parameter int PIX_W      = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             input_valid,
   input  logic [PIX_W-1:0] input_pixel,
   output logic             output_valid,
   output logic [PIX_W-1:0] output_pixel_1,
   output logic [PIX_W-1:0] output_pixel_2,
   output logic [PIX_W-1:0] output_pixel_3,
   output logic [PIX_W-1:0] output_pixel_4,
   output logic [PIX_W-1:0] output_pixel_5,
   output logic [PIX_W-1:0] output_pixel_6,
   output logic [PIX_W-1:0] output_pixel_7,
   output logic [PIX_W-1:0] output_pixel_8,
   output logic [PIX_W-1:0] output_pixel_9,
   output logic             frame_done,
   output logic             busy
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);

   typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_t;

   state_t           state;
   logic [CW-1:0]    in_col;
   logic [CW-1:0]    out_col;
   logic [RW-1:0]    in_row;
   logic [RW-1:0]    out_row;

   // line_prev1[c] holds the pixel one row above the input position,
   // line_prev2[c] the pixel two rows above.
   logic [PIX_W-1:0] line_prev1 [IMG_WIDTH];
   logic [PIX_W-1:0] line_prev2 [IMG_WIDTH];
   logic [PIX_W-1:0] tap1;
   logic [PIX_W-1:0] tap2;

   // Column vectors {top, mid, bot}: new_* is the column being assembled
   // this step, col_a_* the previous one, col_b_* the one before that.
   logic [PIX_W-1:0] new_top, new_mid, new_bot;
   logic [PIX_W-1:0] col_a_top, col_a_mid, col_a_bot;
   logic [PIX_W-1:0] col_b_top, col_b_mid, col_b_bot;
   logic [PIX_W-1:0] left_top, left_mid, left_bot;
   logic [PIX_W-1:0] right_top, right_mid, right_bot;

   logic flushing;
   logic accept;
   logic step;
   logic emit;
   logic last_in;
   logic last_out;

   assign flushing = (state == FLUSH);
   assign accept   = input_valid && !flushing;
   assign step     = accept || flushing;
   assign emit     = ((state == STREAM) && accept) || flushing;
   assign last_in  = (in_row == ROW_LAST) && (in_col == COL_LAST);
   assign last_out = (out_row == ROW_LAST) && (out_col == COL_LAST);
   assign busy     = (state != IDLE);
   assign tap1     = line_prev1[in_col];
   assign tap2     = line_prev2[in_col];

   // Assemble the incoming column and apply row/column edge replication.
   // During flush the virtual row below the image replicates the last row.
   always_comb begin
      new_bot   = flushing ? tap1 : input_pixel;
      new_mid   = tap1;
      new_top   = (!flushing && (in_row == ROW_ONE)) ? tap1 : tap2;
      left_top  = (out_col == '0) ? col_a_top : col_b_top;
      left_mid  = (out_col == '0) ? col_a_mid : col_b_mid;
      left_bot  = (out_col == '0) ? col_a_bot : col_b_bot;
      right_top = (out_col == COL_LAST) ? col_a_top : new_top;
      right_mid = (out_col == COL_LAST) ? col_a_mid : new_mid;
      right_bot = (out_col == COL_LAST) ? col_a_bot : new_bot;
   end

   // Line buffers and column shift registers advance once per input or flush step.
   always_ff @(posedge clk) begin
      if (step) begin
         line_prev1[in_col] <= new_bot;
         line_prev2[in_col] <= tap1;
         col_b_top <= col_a_top;
         col_b_mid <= col_a_mid;
         col_b_bot <= col_a_bot;
         col_a_top <= new_top;
         col_a_mid <= new_mid;
         col_a_bot <= new_bot;
      end
   end

   // Frame sequencing, position counters and registered window outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         in_col         <= '0;
         in_row         <= '0;
         out_col        <= '0;
         out_row        <= '0;
         output_valid   <= 1'b0;
         frame_done     <= 1'b0;
         output_pixel_1 <= '0;
         output_pixel_2 <= '0;
         output_pixel_3 <= '0;
         output_pixel_4 <= '0;
         output_pixel_5 <= '0;
         output_pixel_6 <= '0;
         output_pixel_7 <= '0;
         output_pixel_8 <= '0;
         output_pixel_9 <= '0;
      end else begin
         output_valid <= emit;
         frame_done   <= flushing && last_out;
         if (emit) begin
            output_pixel_1 <= left_top;
            output_pixel_2 <= col_a_top;
            output_pixel_3 <= right_top;
            output_pixel_4 <= left_mid;
            output_pixel_5 <= col_a_mid;
            output_pixel_6 <= right_mid;
            output_pixel_7 <= left_bot;
            output_pixel_8 <= col_a_bot;
            output_pixel_9 <= right_bot;
            if (out_col == COL_LAST) begin
               out_col <= '0;
               out_row <= (out_row == ROW_LAST) ? '0 : out_row + 1'b1;
            end else begin
               out_col <= out_col + 1'b1;
            end
         end
         if (step) begin
            in_col <= (in_col == COL_LAST) ? '0 : in_col + 1'b1;
         end
         if (accept && (in_col == COL_LAST)) begin
            in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
         end
         case (state)
            IDLE:    if (accept) state <= FILL;
            FILL:    if (accept && (in_row == ROW_ONE) && (in_col == '0)) state <= STREAM;
            STREAM:  if (accept && last_in) state <= FLUSH;
            FLUSH: begin
               if (last_out) begin
                  state  <= IDLE;
                  in_col <= '0;
                  in_row <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_window_3x3_line_buffer.sv
// Bench for window_3x3_line_buffer at W=4, H=4: randomised input gaps and
// pixel values, expected windows built from clamped raster coordinates and
// queued with their expected output cycle, popped by an independent monitor.
module tb_window_3x3_line_buffer;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int PW = 24;
   localparam int N  = W * H;

   typedef struct packed {
      logic [9*PW-1:0] win;
      logic            fd;
      logic [31:0]     edge_no;
      logic [31:0]     k;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          input_valid;
   logic [PW-1:0] input_pixel;
   logic          output_valid;
   logic [PW-1:0] output_pixel_1, output_pixel_2, output_pixel_3;
   logic [PW-1:0] output_pixel_4, output_pixel_5, output_pixel_6;
   logic [PW-1:0] output_pixel_7, output_pixel_8, output_pixel_9;
   logic          frame_done;
   logic          busy;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   logic [PW-1:0] frame_pix [N];
   exp_t          sb [$];
   exp_t          mon_e;
   logic [9*PW-1:0] mon_act;

   window_3x3_line_buffer #(
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H),
      .PIX_W     (PW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .input_valid   (input_valid),
      .input_pixel   (input_pixel),
      .output_valid  (output_valid),
      .output_pixel_1(output_pixel_1),
      .output_pixel_2(output_pixel_2),
      .output_pixel_3(output_pixel_3),
      .output_pixel_4(output_pixel_4),
      .output_pixel_5(output_pixel_5),
      .output_pixel_6(output_pixel_6),
      .output_pixel_7(output_pixel_7),
      .output_pixel_8(output_pixel_8),
      .output_pixel_9(output_pixel_9),
      .frame_done    (frame_done),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int clampi(input int v, input int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   // Window k centred at (k/W, k%W), neighbours clamped into the image.
   function automatic logic [9*PW-1:0] model_win(input int k);
      logic [9*PW-1:0] w;
      int r, c, pos;
      w = '0;
      r = k / W;
      c = k % W;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            pos = (dr + 1) * 3 + (dc + 1);
            w[(8 - pos)*PW +: PW] = frame_pix[clampi(r + dr, H - 1) * W + clampi(c + dc, W - 1)];
         end
      end
      return w;
   endfunction

   task automatic push_exp(input int k, input int edge_no);
      exp_t e;
      e.win     = model_win(k);
      e.fd      = (k == N - 1);
      e.edge_no = 32'(edge_no);
      e.k       = 32'(k);
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pixels(input bit random_vals);
      for (int i = 0; i < N; i++) frame_pix[i] = random_vals ? PW'($urandom) : PW'(i);
   endtask

   // Drive one frame; stop_at >= 0 returns right after that input is accepted.
   task automatic send_frame(input int gap_pct, input bit hold_in_flush, input int stop_at);
      int e;
      e = 0;
      for (int i = 0; i < N; i++) begin
         while (int'($urandom_range(99)) < gap_pct) begin
            input_valid = 1'b0;
            input_pixel = PW'($urandom);
            tick();
         end
         input_valid = 1'b1;
         input_pixel = frame_pix[i];
         e = cyc + 1;
         if (i >= W + 1) push_exp(i - W - 1, e);
         tick();
         if (i == stop_at) begin
            input_valid = 1'b0;
            return;
         end
      end
      for (int m = 1; m <= W + 1; m++) push_exp(N - W - 2 + m, e + m);
      for (int m = 1; m <= W + 1; m++) begin
         input_valid = hold_in_flush ? 1'b1 : 1'($urandom_range(1));
         input_pixel = PW'($urandom);
         tick();
      end
      input_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d windows outstanding, required 0", sb.size());
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_idle: got %b, required 0", busy);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (output_valid !== 1'b0 || frame_done !== 1'b0) begin
         errors++;
         $display("FAIL %s_ctrl: valid=%b done=%b, required 0 0", tag, output_valid, frame_done);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_busy: got %b, required 0", tag, busy);
      end
      checks++;
      if ({output_pixel_1, output_pixel_2, output_pixel_3, output_pixel_4, output_pixel_5,
           output_pixel_6, output_pixel_7, output_pixel_8, output_pixel_9} !== '0) begin
         errors++;
         $display("FAIL %s_pixels: got %h, required 0", tag,
                  {output_pixel_1, output_pixel_2, output_pixel_3, output_pixel_4, output_pixel_5,
                   output_pixel_6, output_pixel_7, output_pixel_8, output_pixel_9});
      end
   endtask

   // Monitor: every presented window must match the next expected one.
   always @(negedge clk) begin
      if (!rst) begin
         if (output_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_window: output_valid=1 at cycle %0d, required none", cyc);
            end else begin
               mon_e   = sb.pop_front();
               mon_act = {output_pixel_1, output_pixel_2, output_pixel_3, output_pixel_4,
                          output_pixel_5, output_pixel_6, output_pixel_7, output_pixel_8,
                          output_pixel_9};
               checks++;
               if (mon_act !== mon_e.win) begin
                  errors++;
                  $display("FAIL window_%0d: got %h, required %h", mon_e.k, mon_act, mon_e.win);
               end
               checks++;
               if (frame_done !== mon_e.fd) begin
                  errors++;
                  $display("FAIL frame_done_%0d: got %b, required %b", mon_e.k, frame_done, mon_e.fd);
               end
               checks++;
               if (32'(cyc) !== mon_e.edge_no) begin
                  errors++;
                  $display("FAIL timing_%0d: at cycle %0d, required %0d", mon_e.k, cyc, mon_e.edge_no);
               end
            end
         end else if (frame_done) begin
            checks++;
            errors++;
            $display("FAIL frame_done_alone: got 1 with output_valid=0, required 0");
         end
      end
   end

   initial begin
      rst         = 1'b1;
      input_valid = 1'b0;
      input_pixel = '0;
      tick();
      tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // Continuous identity frame.
      set_pixels(1'b0);
      send_frame(0, 1'b0, -1);
      drain();

      // Same frame with random input gaps.
      send_frame(50, 1'b0, -1);
      drain();

      // Abort mid-frame with reset after input 9, then a clean frame.
      send_frame(0, 1'b0, 9);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_active: got %b, required 1", busy);
      end
      rst = 1'b1;
      sb.delete();
      #1;
      check_reset_outputs("midreset");
      tick();
      tick();
      rst = 1'b0;
      tick();
      send_frame(0, 1'b0, -1);
      drain();

      // Back-to-back frames with input_valid held through flush.
      send_frame(0, 1'b1, -1);
      set_pixels(1'b1);
      send_frame(0, 1'b1, -1);
      drain();

      // Random pixels with random gaps.
      for (int f = 0; f < 3; f++) begin
         set_pixels(1'b1);
         send_frame(40, 1'b0, -1);
         drain();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
